// File: rtl/cipher_regfile_pkg.sv
// cipher_regfile_pkg: register map, bit positions and FSM encoding for cipher_regfile_bank.
package cipher_regfile_pkg;
   localparam int unsigned ADDR_SEL    = 'h00;
   localparam int unsigned ADDR_CTRL   = 'h02;
   localparam int unsigned ADDR_STATUS = 'h04;
   localparam int CTRL_COMMIT   = 0;
   localparam int CTRL_LOCK     = 1;
   localparam int STAT_PENDING  = 0;
   localparam int STAT_LOCK     = 1;
   localparam int STAT_LAST_ERR = 2;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_RESP = 2'd1, ST_RELEASE = 2'd2} state_e;
endpackage

// File: rtl/cipher_regfile_bank_shadow_reg.sv
// regfile_shadow_reg: host-written shadow register plus active copy loaded on commit.
module regfile_shadow_reg #(
   parameter int W = 16,
   parameter logic [W-1:0] RESET = '0
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         wr_en_i,
   input  logic [W-1:0] wdata_i,
   input  logic         commit_i,
   output logic [W-1:0] shadow_o,
   output logic [W-1:0] active_o
);
   logic [W-1:0] shadow_q, shadow_d, active_q, active_d;
   // commit copies the pre-write shadow, so a same-edge write is not applied
   assign shadow_d = wr_en_i ? wdata_i : shadow_q;
   assign active_d = commit_i ? shadow_q : active_q;
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         shadow_q <= RESET;
         active_q <= RESET;
      end else begin
         shadow_q <= shadow_d;
         active_q <= active_d;
      end
   end
   assign shadow_o = shadow_q;
   assign active_o = active_q;
endmodule

// File: rtl/cipher_regfile_bank.sv
// cipher_regfile_bank: handshake register bank holding shadow/active cipher select and keys.
module cipher_regfile_bank
   import cipher_regfile_pkg::*;
#(
   parameter int ADDR_WIDTH = 8,
   parameter int REG_WIDTH  = 16,
   parameter int NUM_KEYS   = 3,
   parameter logic [ADDR_WIDTH-1:0] KEY_BASE = 8'h10,
   parameter logic [NUM_KEYS*REG_WIDTH-1:0] KEY_RESET = {16'h0002, 16'hFFFF, 16'h0000},
   parameter logic [REG_WIDTH-1:0] SEL_RESET = 16'h0000
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [ADDR_WIDTH-1:0]         addr,
   input  logic                          read,
   input  logic                          write,
   input  logic [REG_WIDTH-1:0]          wdata,
   output logic [REG_WIDTH-1:0]          rdata,
   output logic                          done,
   output logic                          error,
   input  logic                          engine_busy,
   output logic [REG_WIDTH-1:0]          select,
   output logic [NUM_KEYS*REG_WIDTH-1:0] keys,
   output logic                          commit_pending
);
   state_e state_q, state_d;
   logic [REG_WIDTH-1:0] rdata_q, rdata_d, sel_shadow, key_rd, ctrl_rd, status_rd, rd_val;
   logic [NUM_KEYS*REG_WIDTH-1:0] key_shadow;
   logic [NUM_KEYS-1:0] key_hit, key_we;
   logic err_q, err_d, pend_q, pend_d, lock_q, lock_d, last_err_q, last_err_d;
   logic req, is_sel, is_ctrl, is_status, is_key, acc_err, wr_ok, ctrl_we, apply;
   assign req       = (state_q == ST_IDLE) && (read || write);
   assign is_sel    = addr == ADDR_WIDTH'(ADDR_SEL);
   assign is_ctrl   = addr == ADDR_WIDTH'(ADDR_CTRL);
   assign is_status = addr == ADDR_WIDTH'(ADDR_STATUS);
   assign is_key    = |key_hit;
   assign acc_err   = (read && write) || !(is_sel || is_ctrl || is_status || is_key) ||
                      (write && is_status) || (write && lock_q && (is_sel || is_key));
   assign wr_ok     = req && write && !acc_err;
   assign ctrl_we   = wr_ok && is_ctrl;
   assign apply     = pend_q && !engine_busy;
   regfile_shadow_reg #(.W(REG_WIDTH), .RESET(SEL_RESET)) u_sel (
      .clk(clk), .rst_n(rst_n), .wr_en_i(wr_ok && is_sel), .wdata_i(wdata),
      .commit_i(apply), .shadow_o(sel_shadow), .active_o(select)
   );
   for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
      assign key_hit[k] = addr == ADDR_WIDTH'(KEY_BASE + 2 * k);
      assign key_we[k]  = wr_ok && key_hit[k];
      regfile_shadow_reg #(.W(REG_WIDTH), .RESET(KEY_RESET[k*REG_WIDTH +: REG_WIDTH])) u_key (
         .clk(clk), .rst_n(rst_n), .wr_en_i(key_we[k]), .wdata_i(wdata), .commit_i(apply),
         .shadow_o(key_shadow[k*REG_WIDTH +: REG_WIDTH]), .active_o(keys[k*REG_WIDTH +: REG_WIDTH])
      );
   end
   always_comb begin
      key_rd = '0;
      for (int i = 0; i < NUM_KEYS; i++) key_rd = key_hit[i] ? key_shadow[i*REG_WIDTH +: REG_WIDTH] : key_rd;
      ctrl_rd = '0;
      ctrl_rd[CTRL_LOCK] = lock_q;
      status_rd = '0;
      status_rd[STAT_PENDING]  = pend_q;
      status_rd[STAT_LOCK]     = lock_q;
      status_rd[STAT_LAST_ERR] = last_err_q;
      rd_val = is_sel ? sel_shadow : is_ctrl ? ctrl_rd : is_status ? status_rd : key_rd;
   end
   always_comb begin
      rdata_d    = req ? ((read && !acc_err) ? rd_val : '0) : rdata_q;
      err_d      = req ? acc_err : err_q;
      last_err_d = req ? acc_err : last_err_q;
      lock_d     = ctrl_we ? wdata[CTRL_LOCK] : lock_q;
      pend_d     = (ctrl_we && wdata[CTRL_COMMIT]) ? 1'b1 : apply ? 1'b0 : pend_q;
   end
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         rdata_q    <= '0;
         err_q      <= 1'b0;
         last_err_q <= 1'b0;
         lock_q     <= 1'b0;
         pend_q     <= 1'b0;
      end else begin
         rdata_q    <= rdata_d;
         err_q      <= err_d;
         last_err_q <= last_err_d;
         lock_q     <= lock_d;
         pend_q     <= pend_d;
      end
   end
   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) state_q <= ST_IDLE;
      else state_q <= state_d;
   end
   always_comb begin
      state_d = (state_q == ST_IDLE)    ? (req ? ST_RESP : ST_IDLE) :
                (state_q == ST_RESP)    ? ST_RELEASE :
                (read || write)         ? ST_RELEASE : ST_IDLE;
   end
   always_comb begin
      done           = state_q == ST_RESP;
      rdata          = done ? rdata_q : '0;
      error          = done && err_q;
      commit_pending = pend_q;
   end
endmodule

// File: doc/cipher_regfile_bank.md
Name: cipher_regfile_bank

Overview:
- Parametrised register bank for the decryption datapath: holds the cipher-select word and NUM_KEYS cipher keys, and drives the MUX/DEMUX select and the per-cipher keys.
- Host writes go to shadow registers. The active outputs update atomically on a commit, and only while the datapath is idle, so keys never change mid-message.
- Adds a request/response FSM with held-level handshake, a lock bit, a read-only status register and parametrised reset defaults.

Parameters:
- ADDR_WIDTH, 8, host address width.
- REG_WIDTH, 16, width of every register and data bus.
- NUM_KEYS, 3, number of cipher key registers (1..8).
- KEY_BASE, 8'h10, address of key 0; key i sits at KEY_BASE + 2*i.
- KEY_RESET, {16'h0002,16'hFFFF,16'h0000}, packed NUM_KEYS*REG_WIDTH reset values; key i uses slice i.
- SEL_RESET, 16'h0000, reset value of select.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-high reset (asserted = 1), despite the name.
- addr  in  ADDR_WIDTH  register address.
- read  in  1  read request, level, held until done.
- write  in  1  write request, level, held until done.
- wdata  in  REG_WIDTH  write data.
- rdata  out  REG_WIDTH  read data, valid while done=1.
- done  out  1  one-cycle access-complete pulse.
- error  out  1  access failed, valid while done=1.
- engine_busy  in  1  datapath is processing; blocks commit.
- select  out  REG_WIDTH  active select to MUX/DEMUX.
- keys  out  NUM_KEYS*REG_WIDTH  active keys, key i at [i*REG_WIDTH +: REG_WIDTH].
- commit_pending  out  1  commit requested, not yet applied.

Behaviour:
- Register map:
  - 0x00 SEL: R/W shadow select.
  - 0x02 CTRL: R/W. bit0 COMMIT is write-1, self-clearing and reads 0. bit1 LOCK.
  - 0x04 STATUS: RO. bit0 commit_pending, bit1 LOCK, bit2 last_error (error of the previous completed access).
  - KEY_BASE+2*i: R/W shadow key i.
  - Any other address is invalid.
- Reset (rst_n=1, asynchronous):
  - Outputs: rdata=0, done=0, error=0, commit_pending=0.
  - Registers: shadow and active select = SEL_RESET; shadow and active keys = KEY_RESET; LOCK=0; last_error=0.
  - FSM returns to IDLE.
- FSM states IDLE, RESP, RELEASE:
  - IDLE: if read|write at a clock edge, latch addr/wdata, perform the access, go to RESP.
  - RESP: done=1 for exactly this cycle; rdata and error are valid. Next state is RELEASE.
  - RELEASE: wait until read=0 and write=0, then go to IDLE. A held request is executed once only.
  - Latency: done is asserted the cycle after the request is sampled.
  - Outside RESP, rdata=0 and error=0.
- Access rules:
  - read=1 and write=1 together: error=1, no write, rdata=0.
  - Invalid address: error=1, no state change, rdata=0. Unlike the previous generation, no registers are reset.
  - Write to STATUS: error=1, ignored.
  - While LOCK=1, writes to SEL or KEY: error=1, shadow unchanged. CTRL remains writable.
  - A read returns the shadow value, not the active value.
  - A successful write to CTRL with bit0=1 sets commit_pending. A new commit while already pending is not an error.
- Commit:
  - On any edge with commit_pending=1 and engine_busy=0: active select and keys load from shadow, and commit_pending clears.
  - If a CTRL commit write and the apply occur on the same edge, pending stays set; the apply uses the pre-write shadow.
  - A shadow write on the same edge as the apply is not included in that apply.
  - If engine_busy stays 1, the commit waits indefinitely. There is no timeout.
- Mid-operation reset: the transaction is aborted, done is not asserted, and the host must re-issue.

Decomposition:
- Package cipher_regfile_pkg holds:
  - address offsets (ADDR_SEL, ADDR_CTRL, ADDR_STATUS);
  - CTRL and STATUS bit indices;
  - the FSM state enum (2-bit encoding).
- One sub-module, regfile_shadow_reg, parametrised by width and reset value. It is a shadow/active pair with wr_en, wdata, commit and reset. It is instantiated once for select and NUM_KEYS times in a generate loop.
- Top level holds the FSM, address decode and status logic.

Test Plan:
- After reset:
  - read 0x00 -> done one cycle later, rdata=0x0000, error=0;
  - read 0x12 -> rdata=0xFFFF;
  - keys bus = {0x0002,0xFFFF,0x0000}.
- Write 0x10=0x0003 -> shadow reads 0x0003, active key0 stays 0x0000. Write CTRL=0x0001 with engine_busy=0 -> commit_pending pulses high then clears, key0 output = 0x0003.
- Hold engine_busy=1, write CTRL=0x0001 -> commit_pending=1 and the STATUS read returns bit0=1, keys unchanged. Drop engine_busy -> keys update on the next edge.
- Error cases, each with done=1 and no register change:
  - read 0x06 -> error=1, rdata=0;
  - write STATUS -> error=1;
  - read=1 and write=1 together -> error=1.
- Write CTRL=0x0002 (lock), then write 0x00=0x0001 -> error=1, SEL reads 0x0000. Write CTRL=0x0000, retry -> SEL=0x0001.
- Hold read=1 for 5 cycles -> exactly one done pulse. Assert rst_n during RESP -> done drops asynchronously and all outputs return to their reset values.
